icache_req_arb: RTL and testbench

ICACHE_REQ_ARB -- requirements
Module: icache_req_arb

---
 rtl/icache_req_arb_pkg.sv | 20 ++
 rtl/icache_ot_fifo.sv | 63 ++++++
 rtl/icache_req_arb.sv | 125 ++++++++++++
 tb/tb_icache_req_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_req_arb_pkg.sv
// icache_req_arb_pkg: shared definitions for the icache request arbiter.
//   FETCH / MAINT : requester ids carried through the outstanding queue
//   ENTRY_W       : width of one outstanding-queue entry {id, kill}
//   state_t       : arbiter states (IDLE = nothing held, HOLD = request presented, awaiting c_addr_ok)
//   ot_entry_t    : outstanding-queue entry layout
package icache_req_arb_pkg;

    localparam logic FETCH = 1'b0;
    localparam logic MAINT = 1'b1;

    typedef enum logic {IDLE, HOLD} state_t;

    typedef struct packed {
        logic id;
        logic kill;
    } ot_entry_t;

    localparam int ENTRY_W = $bits(ot_entry_t);

endpackage

// File: rtl/icache_ot_fifo.sv
// icache_ot_fifo: in-order queue of accepted cache requests awaiting their data.
//   clk, rst     : clock, asynchronous active-high reset (empties queue, clears kill bits)
//   push         : append {push_id, push_kill}; ignored when full
//   pop          : drop head entry; ignored when empty
//   flush_fetch  : set kill on every stored fetch entry
//   head_id/kill : fields of the oldest entry
//   count        : number of stored entries (0..DEPTH)
//   empty, full  : queue status
module icache_ot_fifo
    import icache_req_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_id,
    input  logic                     push_kill,
    input  logic                     pop,
    input  logic                     flush_fetch,
    output logic                     head_id,
    output logic                     head_kill,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    ot_entry_t            mem [DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [ENTRY_W-1:0]   wr_entry;
    logic                 do_push;
    logic                 do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign wr_entry  = {push_id, push_kill};
    assign head_id   = mem[rptr].id;
    assign head_kill = mem[rptr].kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // Kill marking runs first so a same-cycle push writes its own kill value last.
            for (int i = 0; i < DEPTH; i++)
                if (flush_fetch && mem[i].id == FETCH) mem[i].kill <= 1'b1;
            if (do_push) begin
                mem[wptr] <= ot_entry_t'(wr_entry);
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/icache_req_arb.sv
// icache_req_arb: arbitrates fetch and maintenance read requests onto one icache port
// and routes in-order responses back, dropping fetch responses killed by flush_IF.
//   clk, rst                       : clock, asynchronous active-high reset
//   flush_IF                       : fetch redirect; kills fetch responses not yet returned
//   f_valid/f_addr/f_uncached      : fetch request; f_addr_ok accept, f_data_ok/f_rdata response
//   m_valid/m_addr/m_uncached      : maintenance request; m_addr_ok accept, m_data_ok/m_rdata response
//   c_valid/c_addr/c_uncached      : request to cache; c_addr_ok accept, c_data_ok/c_rdata response
//   ot_cnt                         : number of accepted requests still awaiting data
// Build option: define ICACHE_ARB_RR_EN for round-robin grant; otherwise maintenance has
// fixed priority over fetch.
module icache_req_arb
    import icache_req_arb_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int OT_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_IF,
    input  logic                      f_valid,
    input  logic [31:0]               f_addr,
    input  logic                      f_uncached,
    output logic                      f_addr_ok,
    output logic                      f_data_ok,
    output logic [DATA_W-1:0]         f_rdata,
    input  logic                      m_valid,
    input  logic [31:0]               m_addr,
    input  logic                      m_uncached,
    output logic                      m_addr_ok,
    output logic                      m_data_ok,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      c_valid,
    output logic [31:0]               c_addr,
    output logic                      c_uncached,
    input  logic                      c_addr_ok,
    input  logic                      c_data_ok,
    input  logic [DATA_W-1:0]         c_rdata,
    output logic [$clog2(OT_DEPTH):0] ot_cnt
);
    state_t      state;
    logic        gnt_id;
    logic        sel_id;
    logic        any_req;
    logic        accept;
    logic        push_kill;
    logic        full;
    logic        empty;
    logic        head_id;
    logic        head_kill;
    logic        head_ok;
    logic        hold_id;
    logic        hold_unc;
    logic        hold_kill;
    logic [31:0] hold_addr;

`ifdef ICACHE_ARB_RR_EN
    // last_id remembers the most recently accepted requester; the other one wins a tie.
    logic last_id;
    assign gnt_id = (last_id == FETCH) ? (m_valid ? MAINT : FETCH) : (f_valid ? FETCH : MAINT);
`else
    assign gnt_id = m_valid ? MAINT : FETCH;
`endif

    assign any_req    = f_valid | m_valid;
    assign sel_id     = (state == HOLD) ? hold_id : gnt_id;
    // Full is the registered count, so a same-cycle pop never opens a slot early.
    assign c_valid    = ~rst & ~full & ((state == HOLD) | any_req);
    assign c_addr     = (state == HOLD) ? hold_addr : ((gnt_id == MAINT) ? m_addr : f_addr);
    assign c_uncached = (state == HOLD) ? hold_unc : ((gnt_id == MAINT) ? m_uncached : f_uncached);
    assign accept     = c_valid & c_addr_ok;
    assign f_addr_ok  = accept & (sel_id == FETCH);
    assign m_addr_ok  = accept & (sel_id == MAINT);
    // A fetch is dead if a redirect arrived while it waited for c_addr_ok or as it is accepted.
    assign push_kill  = (sel_id == FETCH) & (flush_IF | ((state == HOLD) & hold_kill));
    assign head_ok    = ~rst & c_data_ok & ~empty & ~head_kill;
    assign f_data_ok  = head_ok & (head_id == FETCH);
    assign m_data_ok  = head_ok & (head_id == MAINT);
    assign f_rdata    = rst ? '0 : c_rdata;
    assign m_rdata    = rst ? '0 : c_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_id   <= FETCH;
            hold_addr <= '0;
            hold_unc  <= 1'b0;
            hold_kill <= 1'b0;
`ifdef ICACHE_ARB_RR_EN
            last_id   <= FETCH;
`endif
        end else begin
            if (state == IDLE && c_valid && !c_addr_ok) begin
                state     <= HOLD;
                hold_id   <= gnt_id;
                hold_addr <= c_addr;
                hold_unc  <= c_uncached;
                hold_kill <= flush_IF;
            end else if (state == HOLD) begin
                hold_kill <= hold_kill | flush_IF;
                if (accept) state <= IDLE;
            end
`ifdef ICACHE_ARB_RR_EN
            if (accept) last_id <= sel_id;
`endif
        end
    end

    icache_ot_fifo #(
        .DEPTH (OT_DEPTH)
    ) u_ot_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (accept),
        .push_id     (sel_id),
        .push_kill   (push_kill),
        .pop         (c_data_ok),
        .flush_fetch (flush_IF),
        .head_id     (head_id),
        .head_kill   (head_kill),
        .count       (ot_cnt),
        .empty       (empty),
        .full        (full)
    );

endmodule

// File: tb/tb_icache_req_arb.sv
// tb_icache_req_arb: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_icache_req_arb;
    localparam int DATA_W   = 128;
    localparam int OT_DEPTH = 4;
    localparam int CW       = $clog2(OT_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_IF;
    logic              f_valid, f_uncached, m_valid, m_uncached;
    logic [31:0]       f_addr, m_addr;
    logic              c_addr_ok, c_data_ok;
    logic [DATA_W-1:0] c_rdata;
    logic              f_addr_ok, f_data_ok, m_addr_ok, m_data_ok;
    logic [DATA_W-1:0] f_rdata, m_rdata;
    logic              c_valid, c_uncached;
    logic [31:0]       c_addr;
    logic [CW-1:0]     ot_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit id;
        bit killed;
    } ent_t;

    always #5 clk = ~clk;

    icache_req_arb #(.DATA_W(DATA_W), .OT_DEPTH(OT_DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_IF(flush_IF),
        .f_valid(f_valid), .f_addr(f_addr), .f_uncached(f_uncached),
        .f_addr_ok(f_addr_ok), .f_data_ok(f_data_ok), .f_rdata(f_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_uncached(m_uncached),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .c_valid(c_valid), .c_addr(c_addr), .c_uncached(c_uncached),
        .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok), .c_rdata(c_rdata),
        .ot_cnt(ot_cnt)
    );

    task automatic idle_inputs();
        flush_IF = 0; f_valid = 0; f_uncached = 0; m_valid = 0; m_uncached = 0;
        f_addr = '0; m_addr = '0; c_addr_ok = 0; c_data_ok = 0; c_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; f_valid = 1; m_valid = 1; c_addr_ok = 1; c_data_ok = 1; c_rdata = '1;
        #2;
        n_cmp++;
        if ({c_valid, f_addr_ok, m_addr_ok, f_data_ok, m_data_ok} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b exp 00000", {c_valid, f_addr_ok, m_addr_ok, f_data_ok, m_data_ok});
        end
        n_cmp++;
        if (f_rdata !== '0 || m_rdata !== '0) begin
            n_err++; $display("FAIL reset_rdata: got f=%h m=%h exp 0", f_rdata, m_rdata);
        end
        n_cmp++;
        if (ot_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", ot_cnt); end
        @(posedge clk); #1;
        rst = 0; f_valid = 0; m_valid = 0; c_addr_ok = 0;
        @(negedge clk);
        n_cmp++;
        if ({f_data_ok, m_data_ok, c_valid} !== 3'b0) begin
            n_err++; $display("FAIL empty_data_ok: got %b exp 000", {f_data_ok, m_data_ok, c_valid});
        end
        next_cycle();
        n_cmp++;
        if (ot_cnt !== '0) begin n_err++; $display("FAIL empty_pop_cnt: got %0d exp 0", ot_cnt); end
        c_data_ok = 0;
    endtask

    task automatic test_single_fetch();
        apply_reset();
        f_valid = 1; f_addr = 32'h1c00_0000; c_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({c_valid, f_addr_ok, m_addr_ok} !== 3'b110 || c_addr !== 32'h1c00_0000) begin
            n_err++; $display("FAIL single_req: got %b addr %h exp 110 addr 1c000000", {c_valid, f_addr_ok, m_addr_ok}, c_addr);
        end
        next_cycle();
        f_valid = 0; c_addr_ok = 0; c_data_ok = 1; c_rdata = {4{32'hA5A5_A5A5}};
        n_cmp++;
        if (ot_cnt !== CW'(1)) begin n_err++; $display("FAIL single_cnt1: got %0d exp 1", ot_cnt); end
        @(negedge clk);
        n_cmp++;
        if ({f_data_ok, m_data_ok} !== 2'b10 || f_rdata !== {4{32'hA5A5_A5A5}}) begin
            n_err++; $display("FAIL single_data: got %b %h exp 10 a5..", {f_data_ok, m_data_ok}, f_rdata);
        end
        next_cycle();
        c_data_ok = 0;
        n_cmp++;
        if (ot_cnt !== '0) begin n_err++; $display("FAIL single_cnt0: got %0d exp 0", ot_cnt); end
    endtask

    task automatic test_priority();
        logic [1:0] exp;
        apply_reset();
        f_valid = 1; m_valid = 1; f_addr = 32'h1c00_0100; m_addr = 32'h0000_2000;
        c_addr_ok = 1; c_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef ICACHE_ARB_RR_EN
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp = 2'b10;
`endif
            n_cmp++;
            if ({m_addr_ok, f_addr_ok} !== exp) begin
                n_err++; $display("FAIL prio_grant%0d: got {m,f}=%b exp %b", i, {m_addr_ok, f_addr_ok}, exp);
            end
            next_cycle();
        end
        m_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({m_addr_ok, f_addr_ok} !== 2'b01 || c_addr !== 32'h1c00_0100) begin
            n_err++; $display("FAIL prio_fetch: got {m,f}=%b addr %h exp 01 1c000100", {m_addr_ok, f_addr_ok}, c_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_hold();
        apply_reset();
        f_valid = 1; f_addr = 32'h1c00_0000; f_uncached = 1;
        @(negedge clk);
        n_cmp++;
        if ({c_valid, f_addr_ok} !== 2'b10 || c_addr !== 32'h1c00_0000) begin
            n_err++; $display("FAIL hold_first: got %b %h exp 10 1c000000", {c_valid, f_addr_ok}, c_addr);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            f_addr = 32'h1c00_0010; f_uncached = 0; f_valid = (i != 1);
            m_valid = 1; m_addr = 32'h2000_0000;
            @(negedge clk);
            n_cmp++;
            if ({c_valid, c_uncached, f_addr_ok, m_addr_ok} !== 4'b1100 || c_addr !== 32'h1c00_0000) begin
                n_err++; $display("FAIL hold_keep%0d: got %b %h exp 1100 1c000000", i, {c_valid, c_uncached, f_addr_ok, m_addr_ok}, c_addr);
            end
        end
        next_cycle();
        c_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({f_addr_ok, m_addr_ok} !== 2'b10 || c_addr !== 32'h1c00_0000) begin
            n_err++; $display("FAIL hold_accept: got %b %h exp 10 1c000000", {f_addr_ok, m_addr_ok}, c_addr);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({f_addr_ok, m_addr_ok} !== 2'b01 || c_addr !== 32'h2000_0000) begin
            n_err++; $display("FAIL hold_after: got %b %h exp 01 20000000", {f_addr_ok, m_addr_ok}, c_addr);
        end
        next_cycle();
        idle_inputs();
        n_cmp++;
        if (ot_cnt !== CW'(2)) begin n_err++; $display("FAIL hold_cnt: got %0d exp 2", ot_cnt); end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] d;
        apply_reset();
        c_addr_ok = 1; f_valid = 1; f_addr = 32'h1c00_0040;
        next_cycle();
        f_addr = 32'h1c00_0044;
        next_cycle();
        f_valid = 0; m_valid = 1; m_addr = 32'h0000_3000;
        next_cycle();
        m_valid = 0; flush_IF = 1;
        next_cycle();
        flush_IF = 0;
        n_cmp++;
        if (ot_cnt !== CW'(3)) begin n_err++; $display("FAIL flush_cnt3: got %0d exp 3", ot_cnt); end
        c_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({f_data_ok, m_data_ok} !== ((i == 2) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL flush_resp%0d: got %b exp %b", i, {f_data_ok, m_data_ok}, (i == 2) ? 2'b01 : 2'b00);
            end
            next_cycle();
        end
        c_data_ok = 0;
        n_cmp++;
        if (ot_cnt !== '0) begin n_err++; $display("FAIL flush_cnt0: got %0d exp 0", ot_cnt); end
        f_valid = 1; f_addr = 32'h1c00_0080;
        next_cycle();
        f_valid = 0; c_data_ok = 1; d = {$urandom, $urandom, $urandom, $urandom}; c_rdata = d;
        @(negedge clk);
        n_cmp++;
        if (f_data_ok !== 1'b1 || f_rdata !== d) begin
            n_err++; $display("FAIL flush_next: got ok=%b %h exp 1 %h", f_data_ok, f_rdata, d);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full();
        apply_reset();
        c_addr_ok = 1; f_valid = 1;
        for (int i = 0; i < OT_DEPTH; i++) begin
            f_addr = 32'h1c00_0000 + 32'(i * 4);
            @(negedge clk);
            n_cmp++;
            if (f_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_fill%0d: got %b exp 1", i, f_addr_ok); end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if ({c_valid, f_addr_ok} !== 2'b00 || ot_cnt !== CW'(OT_DEPTH)) begin
            n_err++; $display("FAIL full_block: got %b cnt %0d exp 00 cnt %0d", {c_valid, f_addr_ok}, ot_cnt, OT_DEPTH);
        end
        next_cycle();
        c_data_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({c_valid, f_addr_ok, f_data_ok} !== 3'b001) begin
            n_err++; $display("FAIL full_nobypass: got %b exp 001", {c_valid, f_addr_ok, f_data_ok});
        end
        next_cycle();
        c_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if ({c_valid, f_addr_ok} !== 2'b11 || ot_cnt !== CW'(OT_DEPTH - 1)) begin
            n_err++; $display("FAIL full_reopen: got %b cnt %0d exp 11 cnt %0d", {c_valid, f_addr_ok}, ot_cnt, OT_DEPTH - 1);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        c_addr_ok = 1; f_valid = 1;
        next_cycle();
        next_cycle();
        c_addr_ok = 0;
        n_cmp++;
        if (ot_cnt !== CW'(2)) begin n_err++; $display("FAIL areset_cnt2: got %0d exp 2", ot_cnt); end
        next_cycle();
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({c_valid, f_addr_ok, f_data_ok} !== 3'b000 || ot_cnt !== '0) begin
            n_err++; $display("FAIL areset_now: got %b cnt %0d exp 000 cnt 0", {c_valid, f_addr_ok, f_data_ok}, ot_cnt);
        end
        @(posedge clk); #1;
        rst = 0; f_valid = 0; c_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({c_valid, f_data_ok, m_data_ok} !== 3'b000 || ot_cnt !== '0) begin
                n_err++; $display("FAIL areset_after%0d: got %b cnt %0d exp 000 cnt 0", i, {c_valid, f_data_ok, m_data_ok}, ot_cnt);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        ent_t        q[$];
        bit          pend, pend_id, pend_unc, pend_kill, last;
        logic [31:0] pend_addr, eaddr;
        bit          full, ereq, ecv, eacc, eid, eunc, pop_ok, efd, emd;
        apply_reset();
        pend = 0; pend_kill = 0; pend_id = 0; pend_unc = 0; pend_addr = '0; last = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            f_valid    = $urandom_range(0, 9) < 6;
            m_valid    = $urandom_range(0, 9) < 4;
            f_addr     = $urandom; m_addr = $urandom;
            f_uncached = $urandom_range(0, 1); m_uncached = $urandom_range(0, 1);
            c_addr_ok  = $urandom_range(0, 1);
            c_data_ok  = $urandom_range(0, 9) < 4;
            flush_IF   = $urandom_range(0, 9) == 0;
            c_rdata    = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            full = q.size() == OT_DEPTH;
            if (pend) begin
                ereq = 1; eid = pend_id; eaddr = pend_addr; eunc = pend_unc;
            end else begin
                ereq = f_valid | m_valid;
`ifdef ICACHE_ARB_RR_EN
                eid = (f_valid && m_valid) ? !last : m_valid;
`else
                eid = m_valid;
`endif
                eaddr = eid ? m_addr : f_addr;
                eunc  = eid ? m_uncached : f_uncached;
            end
            ecv    = ereq && !full;
            eacc   = ecv && c_addr_ok;
            pop_ok = c_data_ok && q.size() > 0;
            efd    = pop_ok && q[0].id == 0 && !q[0].killed;
            emd    = pop_ok && q[0].id == 1 && !q[0].killed;
            n_cmp++;
            if (c_valid !== ecv) begin n_err++; $display("FAIL rnd_c_valid cyc %0d: got %b exp %b", cyc, c_valid, ecv); end
            if (ecv) begin
                n_cmp++;
                if (c_addr !== eaddr || c_uncached !== eunc) begin
                    n_err++; $display("FAIL rnd_c_addr cyc %0d: got %h/%b exp %h/%b", cyc, c_addr, c_uncached, eaddr, eunc);
                end
            end
            n_cmp++;
            if ({f_addr_ok, m_addr_ok} !== {eacc && !eid, eacc && eid}) begin
                n_err++; $display("FAIL rnd_addr_ok cyc %0d: got %b exp %b", cyc, {f_addr_ok, m_addr_ok}, {eacc && !eid, eacc && eid});
            end
            n_cmp++;
            if ({f_data_ok, m_data_ok} !== {efd, emd}) begin
                n_err++; $display("FAIL rnd_data_ok cyc %0d: got %b exp %b", cyc, {f_data_ok, m_data_ok}, {efd, emd});
            end
            if (efd || emd) begin
                n_cmp++;
                if ((efd ? f_rdata : m_rdata) !== c_rdata) begin
                    n_err++; $display("FAIL rnd_rdata cyc %0d: got %h exp %h", cyc, efd ? f_rdata : m_rdata, c_rdata);
                end
            end
            n_cmp++;
            if (ot_cnt !== CW'(q.size())) begin n_err++; $display("FAIL rnd_cnt cyc %0d: got %0d exp %0d", cyc, ot_cnt, q.size()); end
            if (flush_IF) foreach (q[i]) if (q[i].id == 0) q[i].killed = 1;
            if (pop_ok) void'(q.pop_front());
            if (eacc) begin
                q.push_back('{id: eid, killed: !eid && (flush_IF || (pend && pend_kill))});
                pend = 0;
                last = eid;
            end else if (ecv && !pend) begin
                pend = 1; pend_id = eid; pend_addr = eaddr; pend_unc = eunc; pend_kill = flush_IF;
            end else if (pend) begin
                pend_kill = pend_kill | flush_IF;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_priority();
        test_hold();
        test_flush();
        test_full();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
